cache_assoc: RTL
================

Name: cache_assoc

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache; successor to the single-port direct-mapped cache.
- Sits between a core-side read/write port (r1e/w1e) and a slower backing memory reached through a req/ack handshake.
- One word per line. Round-robin victim selection per set. Stalls the requester with busy during refills.

Parameters:
- ADDR_W, 16, address width in words.
- DATA_W, 16, data word width.
- SETS, 8, number of sets; power of 2, at least 2.
- WAYS, 2, ways per set; power of 2, 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- r1e  in  1  read request, sampled only when busy=0.
- read1  in  ADDR_W  read address.
- w1e  in  1  write request, sampled only when busy=0.
- write1  in  ADDR_W  write address.
- writedata  in  DATA_W  write data.
- readout1  out  DATA_W  read data, valid when resp_valid=1.
- readHit  out  1  response came from a hit; meaningful when resp_valid=1.
- resp_valid  out  1  one-cycle completion pulse for a read or write.
- busy  out  1  miss in progress; new requests are ignored.
- mem_req  out  1  backing-memory request, held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = fill.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  writeback data.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  fill data.

Behaviour:
- Address split: index = addr[log2(SETS)-1:0]; tag = addr[ADDR_W-1:log2(SETS)].
- Per way, per set: valid, dirty, tag, data. Per set: round-robin pointer, log2(WAYS) bits, minimum 1.
- Reset (async): all valid, dirty and pointers = 0; outputs readout1 = 0, readHit = 0, resp_valid = 0, busy = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; FSM = IDLE.
- Reset during WB or FILL abandons the transfer. Memory data acked after reset is ignored.
- Arbitration: if w1e and r1e are both high, the write is serviced and the read is dropped.
- FSM states: IDLE, WB, FILL, RESP.
- IDLE, hit:
  - Read: next edge gives readout1 = way data, readHit = 1, resp_valid = 1. Latency is 1 cycle.
  - Write: updates data, sets dirty; next edge gives resp_valid = 1, readHit = 1.
- IDLE, miss:
  - Victim = first invalid way (lowest index), otherwise the way at the pointer.
  - Latch request address, data and op; busy = 1 from the next cycle.
  - Go to WB if the victim is valid and dirty, else go to FILL.
- WB: mem_req = 1, mem_we = 1, mem_addr = {victim tag, index}, mem_wdata = victim data. On mem_ack, go to FILL.
- FILL: mem_req = 1, mem_we = 0, mem_addr = request address. On mem_ack:
  - Install the line: valid = 1, tag = request tag.
  - Read: data = mem_rdata, dirty = 0.
  - Write: data = writedata, dirty = 1.
  - If the victim came from the pointer, advance the pointer modulo WAYS.
  - Go to RESP.
- RESP (one cycle): resp_valid = 1, readHit = 0, readout1 = installed data for reads; busy drops the following cycle, then return to IDLE.
- mem_req deasserts on the edge following mem_ack. resp_valid and readHit are single-cycle pulses. readout1 holds its last value otherwise.
- A mem_ack seen while mem_req = 0 is ignored.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: extra outputs hit_count[31:0] and miss_count[31:0]. They are reset to 0 and incremented once per serviced request in IDLE (hit or miss). Each saturates at 0xFFFFFFFF.
- Undefined: no counter ports and no counter logic.

Decomposition:
- Package cache_pkg: FSM state enum (IDLE, WB, FILL, RESP); clog2-derived INDEX_W, TAG_W, PTR_W constants; line-metadata struct {valid, dirty, tag}.
- One natural sub-module, cache_tag_match: combinational tag compare across WAYS. Outputs hit, hit_way, first_invalid_way and any_invalid.

Test Plan:
- Cold read 0 (default params), memory acks after 3 cycles with 0x00AA → FILL mem_addr = 0; RESP readout1 = 0x00AA, readHit = 0; repeat read 0 → next-cycle readHit = 1, readout1 = 0x00AA.
- Write 1 = 343 (miss, mem_rdata = 0) then read 1 → write resp readHit = 0; read hits with 343; no WB issued.
- Reads 0, 16, 128 (all index 0, WAYS = 2) → third access evicts way 0 (addr 0, clean): no WB, FILL addr 128; re-read 16 hits.
- Write 8 = 0x1234, then reads 16 and 24 (index 0) → eviction of dirty addr 8 gives WB with mem_we = 1, mem_addr = 8, mem_wdata = 0x1234 before the FILL.
- r1e = 1, read1 = 5 and w1e = 1, write1 = 5, writedata = 7 in the same cycle; rst pulsed during a later FILL → only the write completes (a later read 5 returns 7); after reset busy = 0, mem_req = 0, and read 5 misses.
- With CACHE_STATS_EN: 3 hits and 2 misses → hit_count = 3, miss_count = 2; rst → both 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative write-back cache.
// The default-geometry widths here are for reference; modules derive their own from parameters.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } state_t;

  // Tags are stored zero-extended to a fixed width so one struct serves any geometry.
  localparam int TAG_MAX_W = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_SETS   = 8;
  localparam int DEF_WAYS   = 2;
  localparam int INDEX_W    = $clog2(DEF_SETS);
  localparam int TAG_W      = DEF_ADDR_W - INDEX_W;
  localparam int PTR_W      = clog2_min1(DEF_WAYS);

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

endpackage

// File: rtl/cache_tag_match.sv
// Combinational tag compare across all ways of one set; lowest-index way wins
// for both the hit and the first-invalid search.
module cache_tag_match
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]           valid,
  input  logic [WAYS*TAG_MAX_W-1:0] tags,
  input  logic [TAG_MAX_W-1:0]      tag,
  output logic                      hit,
  output logic [WAY_W-1:0]          hit_way,
  output logic [WAY_W-1:0]          first_invalid_way,
  output logic                      any_invalid
);

  logic [WAYS-1:0] match;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
    assign match[gi] = valid[gi] && (tags[gi*TAG_MAX_W +: TAG_MAX_W] == tag);
  end

  always_comb begin
    hit               = 1'b0;
    hit_way           = '0;
    first_invalid_way = '0;
    any_invalid       = 1'b0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!valid[i]) begin
        any_invalid       = 1'b1;
        first_invalid_way = WAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative write-back / write-allocate cache, one word per line,
// round-robin victims per set. Optional hit/miss counters under CACHE_STATS_EN.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r1e,
  input  logic [ADDR_W-1:0] read1,
  input  logic              w1e,
  input  logic [ADDR_W-1:0] write1,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readout1,
  output logic              readHit,
  output logic              resp_valid,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TG_W   = ADDR_W - IDX_W;
  localparam int WAY_W  = clog2_min1(WAYS);
  localparam int LINES  = SETS * WAYS;
  localparam int LINE_W = $clog2(LINES);

  function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] idx, input int way);
    return LINE_W'(int'(idx) * WAYS + way);
  endfunction

  line_meta_t        meta     [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [WAY_W-1:0]  ptr      [SETS];

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [DATA_W-1:0] req_data_reg;
  logic              req_we_reg;
  logic [WAY_W-1:0]  victim_reg;
  logic              victim_ptr_reg;

  // Incoming request: a write always wins over a simultaneous read.
  logic              accept;
  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_MAX_W-1:0] cur_tag;

  assign accept   = (state_reg == IDLE) && (r1e || w1e);
  assign cur_addr = w1e ? write1 : read1;
  assign cur_idx  = cur_addr[IDX_W-1:0];
  assign cur_tag  = TAG_MAX_W'(cur_addr[ADDR_W-1:IDX_W]);

  logic [WAYS-1:0]           set_valid;
  logic [WAYS*TAG_MAX_W-1:0] set_tags;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_set
    assign set_valid[gi]                         = meta[line_of(cur_idx, gi)].valid;
    assign set_tags[gi*TAG_MAX_W +: TAG_MAX_W]   = meta[line_of(cur_idx, gi)].tag;
  end

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] first_invalid_way;
  logic             any_invalid;

  cache_tag_match #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_match (
    .valid             (set_valid),
    .tags              (set_tags),
    .tag               (cur_tag),
    .hit               (hit),
    .hit_way           (hit_way),
    .first_invalid_way (first_invalid_way),
    .any_invalid       (any_invalid)
  );

  logic [WAY_W-1:0]  victim_way;
  logic [LINE_W-1:0] victim_line;
  logic [LINE_W-1:0] hit_line;
  logic              victim_dirty;

  assign victim_way   = any_invalid ? first_invalid_way : ptr[cur_idx];
  assign victim_line  = line_of(cur_idx, int'(victim_way));
  assign hit_line     = line_of(cur_idx, int'(hit_way));
  assign victim_dirty = meta[victim_line].valid && meta[victim_line].dirty;

  // Latched miss context used by WB and FILL.
  logic [IDX_W-1:0]     req_idx;
  logic [TAG_MAX_W-1:0] req_tag;
  logic [LINE_W-1:0]    req_line;

  assign req_idx  = req_addr_reg[IDX_W-1:0];
  assign req_tag  = TAG_MAX_W'(req_addr_reg[ADDR_W-1:IDX_W]);
  assign req_line = line_of(req_idx, int'(victim_reg));

  logic fill_done;
  assign fill_done = (state_reg == FILL) && mem_ack;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && !hit) state_next = victim_dirty ? WB : FILL;
      WB:      if (mem_ack) state_next = FILL;
      FILL:    if (mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      req_we_reg     <= 1'b0;
      victim_reg     <= '0;
      victim_ptr_reg <= 1'b0;
      readout1       <= '0;
      readHit        <= 1'b0;
      resp_valid     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      resp_valid <= 1'b0;
      readHit    <= 1'b0;
      if (accept) begin
        req_addr_reg   <= cur_addr;
        req_data_reg   <= writedata;
        req_we_reg     <= w1e;
        victim_reg     <= victim_way;
        victim_ptr_reg <= !any_invalid;
        if (hit) begin
          resp_valid <= 1'b1;
          readHit    <= 1'b1;
          if (!w1e) readout1 <= data_mem[hit_line];
        end
      end
      if (fill_done) begin
        resp_valid <= 1'b1;
        if (!req_we_reg) readout1 <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) meta[i] <= '0;
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else begin
      if (accept && w1e && hit) begin
        meta[hit_line].dirty <= 1'b1;
      end
      if (fill_done) begin
        meta[req_line] <= '{valid: 1'b1, dirty: req_we_reg, tag: req_tag};
        if (victim_ptr_reg) begin
          ptr[req_idx] <= (ptr[req_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr[req_idx] + 1'b1;
        end
      end
    end
  end

  // Data array carries no reset; validity lives in the metadata.
  always_ff @(posedge clk) begin
    if (accept && w1e && hit) begin
      data_mem[hit_line] <= writedata;
    end else if (fill_done) begin
      data_mem[req_line] <= req_we_reg ? req_data_reg : mem_rdata;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign mem_req   = (state_reg == WB) || (state_reg == FILL);
  assign mem_we    = (state_reg == WB);
  assign mem_addr  = (state_reg == WB)   ? {meta[req_line].tag[TG_W-1:0], req_idx} :
                     (state_reg == FILL) ? req_addr_reg : '0;
  assign mem_wdata = (state_reg == WB) ? data_mem[req_line] : '0;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
